// File: rtl/sram_axi_bridge_if.sv
// sram_axi_bridge_if
//   The AXI4 master-side signals used by sram_axi_bridge. Fixed AXI fields
//   (len, size, burst, lock, cache, prot, ids on the write side, wlast,
//   rready, bready) are tied off by the instantiating top, not carried here.
//   Parameters: ID_W (read ID width), ADDR_W, DATA_W.
//   master modport: drives AR/AW/W request signals, receives readies, R, B.
//   slave modport : the mirror image, for a memory model or interconnect.
interface sram_axi_bridge_if #(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic                bvalid;

  modport master (
    output arid, araddr, arvalid, awaddr, awvalid, wdata, wstrb, wvalid,
    input  arready, rid, rdata, rvalid, awready, wready, bvalid
  );

  modport slave (
    input  arid, araddr, arvalid, awaddr, awvalid, wdata, wstrb, wvalid,
    output arready, rid, rdata, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge
//   Bridges NCH SRAM-like read requesters and one SRAM-like write requester
//   onto a single AXI4 master port. One outstanding read per channel (routed
//   back by ID), one outstanding write. Channel NCH-1 has highest priority.
//   Optional feature macro: SRAM_AXI_RAW_CHECK_EN -- when defined, a read whose
//   word address matches an in-flight write is held off until the write's
//   response has been received.
// Ports:
//   clk, resetn               clock, async active-low reset
//   rd_req/rd_addr            per-channel read requests (addr packed by channel)
//   rd_addr_ok/rd_data_ok     one-hot grant / data-valid per channel
//   rd_rdata                  shared read data
//   wr_req/wr_addr/wr_wstrb/wr_wdata, wr_addr_ok/wr_data_ok   write requester
//   axi                       AXI4 master signals (sram_axi_bridge_if.master)
// Write FSM states:
//   W_IDLE | ready to accept a write request
//   W_SEND | AW and W issued, each drops after its own handshake
//   W_RESP | both handshakes done, waiting for bvalid
module sram_axi_bridge #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int ID_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NCH-1:0]        rd_req,
  input  logic [NCH*ADDR_W-1:0] rd_addr,
  output logic [NCH-1:0]        rd_addr_ok,
  output logic [NCH-1:0]        rd_data_ok,
  output logic [DATA_W-1:0]     rd_rdata,
  input  logic                  wr_req,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W/8-1:0]   wr_wstrb,
  input  logic [DATA_W-1:0]     wr_wdata,
  output logic                  wr_addr_ok,
  output logic                  wr_data_ok,
  sram_axi_bridge_if.master     axi
);

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

  w_state_t            state, state_n;
  logic                aw_done, w_done, aw_valid, w_valid;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W/8-1:0] wr_strb_q;
  logic [DATA_W-1:0]   wr_data_q;

  logic                ar_full;
  logic [ADDR_W-1:0]   ar_addr_q;
  logic [ID_W-1:0]     ar_id_q;
  logic [NCH-1:0]      pending, raw_blk, eligible, grant, r_hit;
  logic [ID_W-1:0]     grant_id;
  logic [ADDR_W-1:0]   grant_addr;
  logic                grant_any;

  // ---------------- read side ----------------
  // Ascending scan so the highest eligible index is the last one to win.
  always_comb begin
    eligible   = rd_req & ~pending & ~raw_blk & {NCH{~ar_full}};
    grant      = '0;
    grant_id   = '0;
    grant_addr = '0;
    grant_any  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (eligible[i]) begin
        grant      = '0;
        grant[i]   = 1'b1;
        grant_id   = ID_W'(i);
        grant_addr = rd_addr[i*ADDR_W +: ADDR_W];
        grant_any  = 1'b1;
      end
    end
  end

  // Only responses for an outstanding ID are delivered.
  always_comb begin
    r_hit = '0;
    for (int i = 0; i < NCH; i++)
      r_hit[i] = axi.rvalid & (axi.rid == ID_W'(i)) & pending[i];
  end

  assign rd_addr_ok  = resetn ? grant : '0;
  assign rd_data_ok  = r_hit;
  assign rd_rdata    = axi.rdata;
  assign axi.arvalid = ar_full;
  assign axi.araddr  = ar_addr_q;
  assign axi.arid    = ar_id_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_full   <= 1'b0;
      ar_addr_q <= '0;
      ar_id_q   <= '0;
      pending   <= '0;
    end else begin
      if (grant_any) begin
        ar_full   <= 1'b1;
        ar_addr_q <= grant_addr;
        ar_id_q   <= grant_id;
      end else if (ar_full && axi.arready) begin
        ar_full   <= 1'b0;
      end
      pending <= (pending & ~r_hit) | grant;
    end
  end

`ifdef SRAM_AXI_RAW_CHECK_EN
  // Word-address compare against the in-flight write, and against a write
  // being accepted in this same cycle.
  always_comb begin
    raw_blk = '0;
    for (int i = 0; i < NCH; i++)
      raw_blk[i] = ((state != W_IDLE) &&
                    (rd_addr[i*ADDR_W+2 +: ADDR_W-2] == wr_addr_q[ADDR_W-1:2])) ||
                   (wr_addr_ok &&
                    (rd_addr[i*ADDR_W+2 +: ADDR_W-2] == wr_addr[ADDR_W-1:2]));
  end
`else
  assign raw_blk = '0;
`endif

  // ---------------- write side ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= W_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      W_IDLE:  if (wr_req) state_n = W_SEND;
      W_SEND:  if ((aw_done || axi.awready) && (w_done || axi.wready)) state_n = W_RESP;
      W_RESP:  if (axi.bvalid) state_n = W_IDLE;
      default: state_n = W_IDLE;
    endcase
  end

  always_comb begin
    wr_addr_ok = 1'b0;
    wr_data_ok = 1'b0;
    aw_valid   = 1'b0;
    w_valid    = 1'b0;
    case (state)
      W_IDLE:  wr_addr_ok = wr_req & resetn;
      W_SEND: begin
        aw_valid = ~aw_done;
        w_valid  = ~w_done;
      end
      W_RESP:  wr_data_ok = axi.bvalid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      wr_addr_q <= '0;
      wr_strb_q <= '0;
      wr_data_q <= '0;
    end else if (state == W_IDLE && wr_req) begin
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      wr_addr_q <= wr_addr;
      wr_strb_q <= wr_wstrb;
      wr_data_q <= wr_wdata;
    end else if (state == W_SEND) begin
      if (aw_valid && axi.awready) aw_done <= 1'b1;
      if (w_valid && axi.wready)   w_done  <= 1'b1;
    end
  end

  assign axi.awvalid = aw_valid;
  assign axi.wvalid  = w_valid;
  assign axi.awaddr  = wr_addr_q;
  assign axi.wstrb   = wr_strb_q;
  assign axi.wdata   = wr_data_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
`timescale 1ns/1ps
module tb_sram_axi_bridge;
  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  rd_req;
  logic [63:0] rd_addr;
  logic [1:0]  rd_addr_ok, rd_data_ok;
  logic [31:0] rd_rdata;
  logic        wr_req;
  logic [31:0] wr_addr, wr_wdata;
  logic [3:0]  wr_wstrb;
  logic        wr_addr_ok, wr_data_ok;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] ar_q[$];  // {arid, araddr}
  logic [33:0] r_q[$];   // {rd_data_ok, rd_rdata}
  logic [31:0] aw_q[$];  // awaddr
  logic [35:0] w_q[$];   // {wstrb, wdata}
  int          b_exp = 0;

  sram_axi_bridge_if #(.ID_W(1), .ADDR_W(AW), .DATA_W(DW)) axi ();

  sram_axi_bridge #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_addr_ok (rd_addr_ok),
    .rd_data_ok (rd_data_ok),
    .rd_rdata   (rd_rdata),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_wstrb   (wr_wstrb),
    .wr_wdata   (wr_wdata),
    .wr_addr_ok (wr_addr_ok),
    .wr_data_ok (wr_data_ok),
    .axi        (axi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every handshake / data_ok the DUT presents must match
  // the head of the matching expectation queue.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (axi.arvalid && axi.arready) begin
        chk("ar_expected", ar_q.size() != 0, 1);
        if (ar_q.size() != 0) chk("ar_id_addr", {axi.arid, axi.araddr}, ar_q.pop_front());
      end
      if (rd_data_ok != 2'b00) begin
        chk("r_expected", r_q.size() != 0, 1);
        if (r_q.size() != 0) chk("r_ok_data", {rd_data_ok, rd_rdata}, r_q.pop_front());
      end
      if (axi.awvalid && axi.awready) begin
        chk("aw_expected", aw_q.size() != 0, 1);
        if (aw_q.size() != 0) chk("aw_addr", axi.awaddr, aw_q.pop_front());
      end
      if (axi.wvalid && axi.wready) begin
        chk("w_expected", w_q.size() != 0, 1);
        if (w_q.size() != 0) chk("w_strb_data", {axi.wstrb, axi.wdata}, w_q.pop_front());
      end
      if (wr_data_ok) begin
        chk("b_expected", b_exp > 0, 1);
        if (b_exp > 0) b_exp--;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    rd_req = 2'b11;
    rd_addr = {32'h0000_0100, 32'h1c00_0000};
    wr_req = 1'b1; wr_addr = '0; wr_wstrb = '0; wr_wdata = '0;
    axi.arready = 0; axi.rid = 0; axi.rdata = '0; axi.rvalid = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0;

    // reset values, requests held high during reset
    smp();
    chk("rst_rd_addr_ok", rd_addr_ok, 0);
    chk("rst_wr_addr_ok", wr_addr_ok, 0);
    chk("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid}, 0);
    chk("rst_addrs", {axi.araddr, axi.awaddr}, 0);
    cyc(); rd_req = 0; wr_req = 0; resetn = 1'b1;

    // priority + AR stall
    cyc(); rd_req = 2'b11;
    smp(); chk("prio_grant", rd_addr_ok, 2'b10); ar_q.push_back({1'b1, 32'h0000_0100});
    cyc(); rd_req = 2'b01;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("stall_arvalid", axi.arvalid, 1);
      chk("stall_ar", {axi.arid, axi.araddr}, {1'b1, 32'h0000_0100});
      chk("stall_no_grant", rd_addr_ok, 0);
      cyc();
    end
    axi.arready = 1;
    smp(); chk("stall_release_ar", {axi.arvalid, axi.arid, axi.araddr}, {2'b11, 32'h0000_0100});
    cyc(); axi.arready = 0;
    smp(); chk("ch0_grant", rd_addr_ok, 2'b01); ar_q.push_back({1'b0, 32'h1c00_0000});
    cyc(); rd_req = 0; axi.arready = 1;
    smp(); chk("ch0_ar", {axi.arvalid, axi.arid, axi.araddr}, {2'b10, 32'h1c00_0000});
    cyc(); axi.arready = 0; rd_req = 2'b11;
    smp(); chk("both_pending", rd_addr_ok, 0); chk("ar_idle", axi.arvalid, 0);

    // out-of-order R, re-eligibility one cycle after clear, spurious R
    cyc(); rd_req = 0; axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'hAAAA_5555;
    r_q.push_back({2'b01, 32'hAAAA_5555});
    cyc(); axi.rid = 1; axi.rdata = 32'h1234_5678; rd_req = 2'b10;
    r_q.push_back({2'b10, 32'h1234_5678});
    smp(); chk("no_grant_on_clear", rd_addr_ok, 0);
    cyc(); axi.rvalid = 0;
    smp(); chk("grant_after_clear", rd_addr_ok, 2'b10); ar_q.push_back({1'b1, 32'h0000_0100});
    cyc(); rd_req = 0; axi.arready = 1; axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'hFFFF_0000;
    smp(); chk("spurious_r", rd_data_ok, 0);
    cyc(); axi.arready = 0; axi.rid = 1; axi.rdata = 32'hCAFE_F00D;
    r_q.push_back({2'b10, 32'hCAFE_F00D});
    cyc(); axi.rvalid = 0;

    // split write handshake, refusal until idle
    cyc(); wr_req = 1; wr_addr = 32'h100; wr_wstrb = 4'b0011; wr_wdata = 32'h0000_1234;
    axi.awready = 0; axi.wready = 1;
    smp(); chk("wr_accept", wr_addr_ok, 1);
    aw_q.push_back(32'h100); w_q.push_back({4'b0011, 32'h0000_1234});
    cyc(); wr_addr = 32'h200; wr_wstrb = 4'hf; wr_wdata = 32'hDEAD_BEEF;
    smp(); chk("send_valids", {axi.awvalid, axi.wvalid}, 2'b11); chk("send_refuse", wr_addr_ok, 0);
    chk("send_awaddr", axi.awaddr, 32'h100);
    cyc();
    smp(); chk("w_dropped", {axi.awvalid, axi.wvalid}, 2'b10); chk("send_refuse2", wr_addr_ok, 0);
    cyc(); axi.awready = 1;
    smp(); chk("aw_held", axi.awvalid, 1);
    cyc(); axi.awready = 0;
    smp(); chk("resp_valids", {axi.awvalid, axi.wvalid}, 0); chk("resp_refuse", wr_addr_ok, 0);
    chk("resp_no_b", wr_data_ok, 0);
    cyc(); axi.bvalid = 1; b_exp++;
    smp(); chk("b_refuse", wr_addr_ok, 0);
    cyc(); axi.bvalid = 0; axi.awready = 1; axi.wready = 1;
    smp(); chk("second_accept", wr_addr_ok, 1);
    aw_q.push_back(32'h200); w_q.push_back({4'hf, 32'hDEAD_BEEF});
    cyc(); wr_req = 0;
    smp(); chk("both_valid", {axi.awvalid, axi.wvalid}, 2'b11);
    cyc(); axi.awready = 0; axi.wready = 0;
    smp(); chk("both_same_cycle", {axi.awvalid, axi.wvalid}, 0); chk("resp_wait", wr_data_ok, 0);
    cyc(); axi.bvalid = 1; b_exp++;
    cyc();
    smp(); chk("b_outside_resp", wr_data_ok, 0);
    cyc(); axi.bvalid = 0;

    // read-after-write to the same word
    cyc(); wr_req = 1; wr_addr = 32'h100; wr_wstrb = 4'hf; wr_wdata = 32'h55; rd_req = 2'b10;
    smp(); chk("raw_wr_accept", wr_addr_ok, 1);
    aw_q.push_back(32'h100); w_q.push_back({4'hf, 32'h55});
`ifdef SRAM_AXI_RAW_CHECK_EN
    chk("raw_block_accept", rd_addr_ok, 0);
`else
    chk("raw_free_grant", rd_addr_ok, 2'b10); ar_q.push_back({1'b1, 32'h0000_0100});
`endif
    cyc(); wr_req = 0; axi.awready = 1; axi.wready = 1; axi.arready = 1;
`ifndef SRAM_AXI_RAW_CHECK_EN
    rd_req = 0;
`endif
    smp(); chk("raw_send", rd_addr_ok, 0);
    cyc(); axi.awready = 0; axi.wready = 0;
    smp(); chk("raw_resp", rd_addr_ok, 0);
    cyc(); axi.bvalid = 1; b_exp++;
    smp(); chk("raw_bvalid_cycle", rd_addr_ok, 0);
    cyc(); axi.bvalid = 0;
    smp();
`ifdef SRAM_AXI_RAW_CHECK_EN
    chk("raw_release", rd_addr_ok, 2'b10); ar_q.push_back({1'b1, 32'h0000_0100});
`else
    chk("raw_pending", rd_addr_ok, 0);
`endif
    cyc(); rd_req = 0;
    cyc(); axi.arready = 0; axi.rvalid = 1; axi.rid = 1; axi.rdata = 32'h0BAD_BEEF;
    r_q.push_back({2'b10, 32'h0BAD_BEEF});
    cyc(); axi.rvalid = 0;

    // concurrent grant + accept, then reset mid-write
    cyc(); wr_req = 1; wr_addr = 32'h300; rd_req = 2'b01;
    smp(); chk("concurrent", {rd_addr_ok, wr_addr_ok}, 3'b011);
    cyc(); wr_req = 0; rd_req = 0;
    smp(); chk("pre_reset_valids", {axi.arvalid, axi.awvalid, axi.wvalid}, 3'b111);
    #1 resetn = 1'b0;
    #1 chk("async_reset_valids", {axi.arvalid, axi.awvalid, axi.wvalid}, 0);
    chk("async_reset_awaddr", axi.awaddr, 0);
    axi.bvalid = 1; axi.rvalid = 1; axi.rid = 0;
    cyc(); cyc(); resetn = 1'b1;
    cyc(); cyc();
    smp(); chk("post_reset_no_ok", {rd_data_ok, wr_data_ok}, 0);
    cyc(); axi.bvalid = 0; axi.rvalid = 0;
    cyc(); cyc();

    chk("ar_q_empty", ar_q.size(), 0);
    chk("r_q_empty", r_q.size(), 0);
    chk("aw_q_empty", aw_q.size(), 0);
    chk("w_q_empty", w_q.size(), 0);
    chk("b_all_seen", b_exp, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
